// File: rtl/wakeup_scheduler_if.sv
// Issue-side and broadcast-side signals of the wakeup scheduler.
// The master is the issue queue; the slave is the scheduler.
interface wakeup_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [3:0]       issue_valid;
  logic [27:0]      issue_rob;
  logic [31:0]      issue_dst;
  logic             issue_stall;
  logic             executed;
  logic [7:0]       executedReg;
  logic [6:0]       complete_rob;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output issue_valid, issue_rob, issue_dst,
    input  issue_stall, executed, executedReg, complete_rob, occupancy
  );

  modport slave (
    input  issue_valid, issue_rob, issue_dst,
    output issue_stall, executed, executedReg, complete_rob, occupancy
  );
endinterface

// File: rtl/wakeup_scheduler.sv
// Fixed-latency 4-wide execution model that serialises completions onto a
// single wakeup/ROB broadcast per cycle, with occupancy-based issue backpressure.
module wakeup_scheduler #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  wakeup_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] STALL_LVL = OCC_W'(DEPTH - 4);

  logic [3:0]       stg_valid_q [LAT];
  logic [6:0]       stg_rob_q   [LAT][4];
  logic [7:0]       stg_dst_q   [LAT][4];

  logic [6:0]       fifo_rob_q [DEPTH];
  logic [7:0]       fifo_dst_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             stall;
  logic             accept;
  logic             pop;
  logic [3:0]       push_lanes;
  logic [2:0]       acc_cnt;
  logic [2:0]       push_cnt;
  logic [PTR_W-1:0] push_addr [4];
  logic [6:0]       lane_rob  [4];
  logic [7:0]       lane_dst  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_rob[gi] = bus.issue_rob[7*gi +: 7];
    assign lane_dst[gi] = bus.issue_dst[8*gi +: 8];
  end

  // Stall depends only on registered occupancy: at most 4 more ops can
  // be accepted, and every in-flight op is guaranteed a FIFO slot.
  assign stall      = occ_q > STALL_LVL;
  assign accept     = ~stall & ~flush;
  assign pop        = (count_q != '0) & ~flush;
  assign push_lanes = stg_valid_q[LAT-1];

  // Compact the valid lanes of the last stage into consecutive FIFO slots.
  always_comb begin
    acc_cnt  = '0;
    push_cnt = '0;
    for (int l = 0; l < 4; l++) begin
      push_addr[l] = wr_ptr_q + PTR_W'(push_cnt);
      push_cnt     = push_cnt + {2'b00, push_lanes[l]};
      acc_cnt      = acc_cnt + {2'b00, bus.issue_valid[l] & accept};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + OCC_W'(push_cnt) - OCC_W'(pop);
    occ_d    = occ_q + OCC_W'(acc_cnt) - OCC_W'(pop);
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int k = 0; k < LAT; k++) stg_valid_q[k] <= '0;
    end else begin
      stg_valid_q[0] <= accept ? bus.issue_valid : 4'b0000;
      for (int k = 1; k < LAT; k++) stg_valid_q[k] <= stg_valid_q[k-1];
    end
  end

  // Payload carries no reset; everything downstream is qualified by valids.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      stg_rob_q[0][l] <= lane_rob[l];
      stg_dst_q[0][l] <= lane_dst[l];
      for (int k = 1; k < LAT; k++) begin
        stg_rob_q[k][l] <= stg_rob_q[k-1][l];
        stg_dst_q[k][l] <= stg_dst_q[k-1][l];
      end
      if (push_lanes[l]) begin
        fifo_rob_q[push_addr[l]] <= stg_rob_q[LAT-1][l];
        fifo_dst_q[push_addr[l]] <= stg_dst_q[LAT-1][l];
      end
    end
  end

  assign bus.issue_stall  = stall;
  assign bus.executed     = pop;
  assign bus.executedReg  = pop ? fifo_dst_q[rd_ptr_q] : 8'h00;
  assign bus.complete_rob = pop ? fifo_rob_q[rd_ptr_q] : 7'h00;
  assign bus.occupancy    = occ_q;
endmodule

// File: tb/tb_wakeup_scheduler.sv
// Self-checking bench for wakeup_scheduler: directed table, hand sequences,
// and random streams checked against an in-order completion-queue model.
module tb_wakeup_scheduler;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  wakeup_scheduler_if #(.DEPTH(DEPTH)) bus ();

  wakeup_scheduler #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: every accepted op in issue order, with the first cycle it may broadcast.
  typedef struct {
    logic [6:0] rob;
    logic [7:0] dst;
    int         ready;
  } op_t;

  typedef struct {
    logic [3:0]  v;
    logic [27:0] rob;
    logic [31:0] dst;
    bit          e_exec;
    logic [7:0]  e_dst;
    logic [6:0]  e_rob;
    int          e_occ;
  } vec_t;

  op_t  q[$];
  vec_t tbl[13];
  int   t        = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  int   bcast    = 0;

  bit   s_exec;
  bit   s_stall;
  int   s_dst;
  int   s_rob;
  int   s_occ;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, t, act, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] v, input logic [27:0] rob, input logic [31:0] dst,
                       input logic fl, input logic rst, input bit chk);
    bit e_exec;
    bit e_stall;
    int e_dst;
    int e_rob;
    int e_occ;
    reset           = rst;
    flush           = fl;
    bus.issue_valid = v;
    bus.issue_rob   = rob;
    bus.issue_dst   = dst;
    #1;
    e_occ   = q.size();
    e_stall = (e_occ > DEPTH - 4);
    e_exec  = !fl && (q.size() > 0) && (q[0].ready <= t);
    e_dst   = e_exec ? int'(q[0].dst) : 0;
    e_rob   = e_exec ? int'(q[0].rob) : 0;
    s_exec  = bus.executed;
    s_stall = bus.issue_stall;
    s_dst   = int'(bus.executedReg);
    s_rob   = int'(bus.complete_rob);
    s_occ   = int'(bus.occupancy);
    if (chk) begin
      check("executed", int'(s_exec), int'(e_exec));
      check("executedReg", s_dst, e_dst);
      check("complete_rob", s_rob, e_rob);
      check("issue_stall", int'(s_stall), int'(e_stall));
      check("occupancy", s_occ, e_occ);
    end
    if (s_exec) begin
      bcast++;
      $display("cyc %0d broadcast rob=%0d dst=0x%02h occ=%0d", t, s_rob, s_dst, s_occ);
    end
    if (!rst || fl) begin
      q.delete();
    end else begin
      if (e_exec) void'(q.pop_front());
      if (!e_stall) begin
        for (int l = 0; l < 4; l++) begin
          if (v[l]) begin
            q.push_back('{rob[7*l +: 7], dst[8*l +: 8], t + LAT + 1});
            accepted++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'h0, 28'h0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic rand_issue(input logic [3:0] v, input logic fl, input logic rst);
    cycle(v, 28'($urandom), $urandom, fl, rst, 1'b1);
  endtask

  initial begin
    int acc0;
    int bc0;
    bit saw_stall;

    // Single lane-2 op, then a full 4-lane group, cycle by cycle.
    tbl[0]  = '{4'b0100, {7'd0, 7'd5, 7'd0, 7'd0}, {8'h00, 8'h21, 8'h00, 8'h00}, 0, 8'h00, 7'd0, 0};
    tbl[1]  = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 1};
    tbl[2]  = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 1};
    tbl[3]  = '{4'b0000, 28'h0, 32'h0, 1, 8'h21, 7'd5, 1};
    tbl[4]  = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 0};
    tbl[5]  = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 32'h13121110, 0, 8'h00, 7'd0, 0};
    tbl[6]  = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 4};
    tbl[7]  = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 4};
    tbl[8]  = '{4'b0000, 28'h0, 32'h0, 1, 8'h10, 7'd1, 4};
    tbl[9]  = '{4'b0000, 28'h0, 32'h0, 1, 8'h11, 7'd2, 3};
    tbl[10] = '{4'b0000, 28'h0, 32'h0, 1, 8'h12, 7'd3, 2};
    tbl[11] = '{4'b0000, 28'h0, 32'h0, 1, 8'h13, 7'd4, 1};
    tbl[12] = '{4'b0000, 28'h0, 32'h0, 0, 8'h00, 7'd0, 0};

    // Reset held two cycles with random issue; outputs read 0 after the first edge.
    cycle(4'($urandom), 28'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
    rand_issue(4'hF, 1'b0, 1'b0);
    check("rst_executed", int'(s_exec), 0);
    check("rst_occupancy", s_occ, 0);
    idle(10);

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].rob, tbl[i].dst, 1'b0, 1'b1, 1'b1);
      check("tbl_executed", int'(s_exec), int'(tbl[i].e_exec));
      check("tbl_executedReg", s_dst, int'(tbl[i].e_dst));
      check("tbl_complete_rob", s_rob, int'(tbl[i].e_rob));
      check("tbl_occupancy", s_occ, tbl[i].e_occ);
    end

    // Backpressure: full-width issue every cycle, including while stalled.
    saw_stall = 0;
    for (int i = 0; i < 40; i++) begin
      rand_issue(4'hF, 1'b0, 1'b1);
      if (s_stall) saw_stall = 1;
    end
    check("stall_seen", int'(saw_stall), 1);
    idle(25);
    check("stall_drained_occ", s_occ, 0);

    // Wrap-around stream with random lane masks and no flush.
    acc0 = accepted;
    bc0  = bcast;
    for (int i = 0; i < 400 && (accepted - acc0) < 150; i++) rand_issue(4'($urandom), 1'b0, 1'b1);
    idle(25);
    check("stream_bcast_count", bcast - bc0, accepted - acc0);
    check("stream_wraps_ge5", int'((bcast - bc0) / DEPTH >= 5), 1);

    // Flush with 6 ops in flight and a same-cycle 4-lane issue.
    rand_issue(4'hF, 1'b0, 1'b1);
    rand_issue(4'h3, 1'b0, 1'b1);
    rand_issue(4'hF, 1'b1, 1'b1);
    check("flush_exec", int'(s_exec), 0);
    check("flush_inflight", s_occ, 6);
    idle(1);
    check("postflush_occ", s_occ, 0);
    check("postflush_stall", int'(s_stall), 0);
    idle(10);

    // Reset mid-operation drops everything in flight.
    for (int i = 0; i < 6; i++) rand_issue(4'($urandom), 1'b0, 1'b1);
    rand_issue(4'hF, 1'b0, 1'b0);
    idle(1);
    check("midrst_occ", s_occ, 0);
    idle(8);

    // Random mix of issue, flush and reset.
    for (int i = 0; i < 300; i++) begin
      rand_issue(4'($urandom), logic'($urandom_range(0, 29) == 0),
                 logic'($urandom_range(0, 79) != 0));
    end
    idle(25);
    check("final_occ", s_occ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wakeup_scheduler.md
Name: wakeup_scheduler

Overview:
- Sits between the 4-wide issue queue and the single-port wakeup/completion bus.
- Takes up to 4 issued micro-ops per cycle and models a fixed functional-unit latency.
- Serialises completions onto one broadcast per cycle, which drives the issue queue's executed/executedReg inputs and the ROB completion port.
- Applies issue backpressure so that no completion is ever dropped.

Parameters:
LAT, 2, execution latency in pipeline stages (>=1)
DEPTH, 16, completion FIFO entries (power of 2, >=8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  discard all in-flight and queued ops
issue_valid  in  4  lane i holds a valid issued op
issue_rob  in  28  lane i ROB index at [7i+6:7i]
issue_dst  in  32  lane i destination phys reg at [8i+7:8i]
issue_stall  out  1  issuer must not present new ops
executed  out  1  completion broadcast valid
executedReg  out  8  broadcast destination phys reg
complete_rob  out  7  broadcast ROB index
occupancy  out  $clog2(DEPTH+1)  ops in pipeline plus FIFO

Behaviour:
- Reset (reset==0 at posedge):
  - All pipeline stage valids clear; FIFO pointers and occupancy go to 0.
  - executed, executedReg, complete_rob, issue_stall and occupancy all read 0 from the next cycle.
  - Reset mid-operation drops everything in flight.
- Accept condition: accept = ~issue_stall & ~flush.
  - When accepted, every lane with issue_valid=1 enters pipeline stage 0 at the clock edge.
  - Lanes with issue_valid=0 are ignored. When not accepted, all inputs are ignored and the issuer holds.
- Pipeline:
  - LAT registered stages, each carrying 4 lanes {valid, rob, dst}, advancing every cycle with no internal stall.
  - An op sampled in cycle c occupies stage k during cycle c+1+k.
- FIFO push:
  - At the end of cycle c+LAT, the valid lanes of the last stage are written into the FIFO compacted in lane order (lane 0 first) at wr_ptr, wr_ptr+1, ... modulo DEPTH.
  - wr_ptr advances by the popcount of those lanes.
- Broadcast:
  - executed = (FIFO non-empty) & ~flush; executedReg and complete_rob come from the FIFO head.
  - One entry pops per cycle whenever executed=1. Each op is broadcast for exactly one cycle.
  - When executed=0, executedReg and complete_rob are driven to 0.
  - Minimum latency: issue in cycle c gives broadcast in cycle c+LAT+1.
- Ordering:
  - Older issue cycles complete first; within a cycle, lower lane completes first.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. Empty is detected by count==0, not by pointer equality.
- Occupancy and stall:
  - occupancy_next = occupancy + accepted_count - popped, with accepted_count in 0..4 and popped in 0..1.
  - issue_stall = (occupancy > DEPTH-4), a registered-count compare (combinational from state only, never from issue_valid).
  - This guarantees the FIFO never overflows, since every pipeline op eventually lands in the FIFO.
  - Simultaneous accept and pop in one cycle are both counted.
- Flush:
  - In the flush cycle, executed=0 and nothing pops; the issue inputs are dropped.
  - At the edge, all stage valids clear, rd_ptr=wr_ptr, and occupancy=0.
  - issue_stall=0 from the next cycle. If reset and flush coincide, reset wins (same result).
- No X may reach outputs. Payload registers need no reset, but outputs are gated by valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random issue inputs -> all outputs 0. After release with no issue, executed remains 0 for 10 cycles.
- Single op: cycle 0, issue_valid=4'b0100, lane2 rob=7'd5, dst=8'h21 (LAT=2) -> cycle 3 executed=1, executedReg=8'h21, complete_rob=5. Cycle 4 executed=0. occupancy 1 during cycles 1-3, 0 in cycle 4.
- Full group: cycle 0, four lanes rob=1,2,3,4, dst=0x10-0x13 -> broadcasts rob 1,2,3,4 in cycles 3,4,5,6 consecutively, then executed=0.
- Backpressure:
  - Drive 4 valid ops every cycle while not stalled (DEPTH=16) -> issue_stall rises the cycle after occupancy reaches 13.
  - Inputs presented during stall are never broadcast.
  - Every accepted op is broadcast exactly once in order.
  - Stall drops once occupancy <= 12.
- Wrap-around: stream 100 ops with random lane masks -> broadcast sequence equals the accepted sequence (scoreboard), with FIFO pointers wrapping at least 5 times.
- Flush mid-operation: with 6 ops in flight, assert flush for 1 cycle alongside a new 4-lane issue -> executed=0 in the flush cycle. Next cycle occupancy=0, issue_stall=0, and no flushed or same-cycle op is ever broadcast.
